// File: rtl/tile_pkg.sv
// tile_pkg: shared constants, state encoding and payload types for the tile
// scheduler and its grid counter.
package tile_pkg;

  localparam int unsigned TILE_W      = 8;
  localparam int unsigned TILE_BYTES  = 192;
  localparam int unsigned MAP_COLS    = 20;
  localparam int unsigned MAP_ROWS    = 15;
  localparam int unsigned NUM_TILES   = 21;
  localparam int unsigned ACK_TIMEOUT = 8;

  localparam int unsigned COL_W      = 5;
  localparam int unsigned ROW_W      = 4;
  localparam int unsigned MAP_ADDR_W = 9;
  localparam int unsigned IDX_W      = 8;
  localparam int unsigned TADDR_W    = 12;
  localparam int unsigned POS_W      = 8;
  localparam int unsigned CNT_W      = 9;
  localparam int unsigned ACK_W      = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned TILE_SH    = $clog2(TILE_W);

  // 8-bit encoding to line up with the drawer's state width
  typedef enum logic [7:0] {
    S_IDLE      = 8'd0,
    S_FETCH     = 8'd1,
    S_CALC      = 8'd2,
    S_ISSUE     = 8'd3,
    S_WAIT_ACK  = 8'd4,
    S_WAIT_DONE = 8'd5,
    S_ADVANCE   = 8'd6,
    S_DONE      = 8'd7
  } state_t;

  typedef enum logic {
    MODE_FULL = 1'b0,
    MODE_CELL = 1'b1
  } mode_t;

  // Parameters handed to the drawer alongside the draw pulse
  typedef struct packed {
    logic [TADDR_W-1:0] addr;
    logic [POS_W-1:0]   x;
    logic [POS_W-1:0]   y;
  } tile_req_t;

  // Tile ROM base byte address: idx * 192 built from two shifts, kept to 12 bits
  function automatic logic [TADDR_W-1:0] tile_base(input logic [IDX_W-1:0] idx);
    logic [TADDR_W-1:0] w;
    w = TADDR_W'(idx);
    return (w << 7) + (w << 6);
  endfunction

endpackage

// File: rtl/tile_grid_counter.sv
// tile_grid_counter: owns the current map cell (col,row) and the map RAM address.
// Ports: clk, rst_n (async active-low); load with load_col/load_row sets the
// cell; step advances in raster order. Outputs col, row, last_cell (cell is the
// final one of the map) and map_addr = row*MAP_COLS + col, all registered.
module tile_grid_counter
  import tile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [COL_W-1:0]      load_col,
  input  logic [ROW_W-1:0]      load_row,
  input  logic                  step,
  output logic [COL_W-1:0]      col,
  output logic [ROW_W-1:0]      row,
  output logic                  last_cell,
  output logic [MAP_ADDR_W-1:0] map_addr
);

  logic [COL_W-1:0] col_n;
  logic [ROW_W-1:0] row_n;

  // Next cell: load has priority over step; column wraps into the next row
  always_comb begin
    col_n = col;
    row_n = row;
    if (load) begin
      col_n = load_col;
      row_n = load_row;
    end else if (step) begin
      if (col == COL_W'(MAP_COLS - 1)) begin
        col_n = '0;
        row_n = (row == ROW_W'(MAP_ROWS - 1)) ? '0 : row + ROW_W'(1);
      end else begin
        col_n = col + COL_W'(1);
      end
    end
  end

  // Address and last-cell flag are computed from the next cell so they are
  // valid in the same cycle the new col/row appear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      map_addr  <= '0;
      last_cell <= 1'b0;
    end else begin
      col       <= col_n;
      row       <= row_n;
      map_addr  <= MAP_ADDR_W'(row_n) * MAP_ADDR_W'(MAP_COLS) + MAP_ADDR_W'(col_n);
      last_cell <= (col_n == COL_W'(MAP_COLS - 1)) && (row_n == ROW_W'(MAP_ROWS - 1));
    end
  end

endmodule

// File: rtl/tile_scheduler.sv
// tile_scheduler: sweeps the tile map and drives the tile drawer one 8x8 tile
// at a time, either over the full map (start) or a single cell (start_cell).
// Ports: clk, resetn (async active-low); start/start_cell with cell_col/cell_row;
// map_addr/map_data to a synchronous map RAM; drawer_active from the drawer;
// draw/tile_address/x_pos/y_pos to the drawer; busy, done, err (sticky) and
// tiles_drawn status. All outputs are registered.
module tile_scheduler
  import tile_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  start_cell,
  input  logic [COL_W-1:0]      cell_col,
  input  logic [ROW_W-1:0]      cell_row,
  output logic [MAP_ADDR_W-1:0] map_addr,
  input  logic [IDX_W-1:0]      map_data,
  input  logic                  drawer_active,
  output logic                  draw,
  output logic [TADDR_W-1:0]    tile_address,
  output logic [POS_W-1:0]      x_pos,
  output logic [POS_W-1:0]      y_pos,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CNT_W-1:0]      tiles_drawn
);

  state_t            state, state_n;
  mode_t             mode, mode_n;
  logic [ACK_W-1:0]  ack_cnt, ack_cnt_n;
  logic              timed_out, timed_out_n;
  tile_req_t         req, req_n;
  logic              draw_n, busy_n, done_n, err_n;
  logic [CNT_W-1:0]  tiles_n;

  logic              g_load, g_step, g_last;
  logic [COL_W-1:0]  g_col, ld_col;
  logic [ROW_W-1:0]  g_row, ld_row;

  tile_grid_counter u_grid (
    .clk       (clk),
    .rst_n     (resetn),
    .load      (g_load),
    .load_col  (ld_col),
    .load_row  (ld_row),
    .step      (g_step),
    .col       (g_col),
    .row       (g_row),
    .last_cell (g_last),
    .map_addr  (map_addr)
  );

  assign tile_address = req.addr;
  assign x_pos        = req.x;
  assign y_pos        = req.y;

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    mode_n      = mode;
    ack_cnt_n   = ack_cnt;
    timed_out_n = timed_out;
    req_n       = req;
    draw_n      = 1'b0;
    busy_n      = 1'b0;
    done_n      = 1'b0;
    err_n       = err;
    tiles_n     = tiles_drawn;
    g_load      = 1'b0;
    g_step      = 1'b0;
    ld_col      = cell_col;
    ld_row      = cell_row;

    case (state)
      S_IDLE: begin
        if (start) begin
          g_load  = 1'b1;
          ld_col  = '0;
          ld_row  = '0;
          mode_n  = MODE_FULL;
          tiles_n = '0;
          err_n   = 1'b0;
          state_n = S_FETCH;
        end else if (start_cell) begin
          tiles_n = '0;
          // Off-map cell: report and finish without leaving idle
          if (cell_col >= COL_W'(MAP_COLS) || cell_row >= ROW_W'(MAP_ROWS)) begin
            err_n  = 1'b1;
            done_n = 1'b1;
          end else begin
            g_load  = 1'b1;
            mode_n  = MODE_CELL;
            err_n   = 1'b0;
            state_n = S_FETCH;
          end
        end
      end
      S_FETCH: state_n = S_CALC;
      S_CALC: begin
        // Bad index still draws something harmless (tile 0) and flags it
        if (map_data >= IDX_W'(NUM_TILES)) begin
          req_n.addr = tile_base(IDX_W'(0));
          err_n      = 1'b1;
        end else begin
          req_n.addr = tile_base(map_data);
        end
        req_n.x = POS_W'(g_col) << TILE_SH;
        req_n.y = POS_W'(g_row) << TILE_SH;
        state_n = S_ISSUE;
      end
      S_ISSUE: begin
        draw_n      = 1'b1;
        ack_cnt_n   = '0;
        timed_out_n = 1'b0;
        state_n     = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (drawer_active) begin
          state_n = S_WAIT_DONE;
        end else if (ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
          // Drawer never picked the tile up; abandon it
          err_n       = 1'b1;
          timed_out_n = 1'b1;
          state_n     = S_ADVANCE;
        end else begin
          ack_cnt_n = ack_cnt + ACK_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!drawer_active) state_n = S_ADVANCE;
      end
      S_ADVANCE: begin
        if (!timed_out) tiles_n = tiles_drawn + CNT_W'(1);
        if (mode == MODE_CELL || g_last) begin
          done_n  = 1'b1;
          state_n = S_DONE;
        end else begin
          g_step  = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n != S_IDLE) && (state_n != S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      mode        <= MODE_FULL;
      ack_cnt     <= '0;
      timed_out   <= 1'b0;
      req         <= '0;
      draw        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      tiles_drawn <= '0;
    end else begin
      state       <= state_n;
      mode        <= mode_n;
      ack_cnt     <= ack_cnt_n;
      timed_out   <= timed_out_n;
      req         <= req_n;
      draw        <= draw_n;
      busy        <= busy_n;
      done        <= done_n;
      err         <= err_n;
      tiles_drawn <= tiles_n;
    end
  end

endmodule

// File: tb/tb_tile_scheduler.sv
// Bench for tile_scheduler: map RAM and drawer models, scoreboard of expected
// draws, directed sequence of passes.
module tb_tile_scheduler;

  localparam int BUSY_LEN = 3;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start, start_cell;
  logic [4:0] cell_col;
  logic [3:0] cell_row;
  logic [8:0] map_addr;
  logic [7:0] map_data;
  logic       drawer_active;
  logic       draw;
  logic [11:0] tile_address;
  logic [7:0] x_pos, y_pos;
  logic       busy, done, err;
  logic [8:0] tiles_drawn;

  tile_scheduler dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .start_cell    (start_cell),
    .cell_col      (cell_col),
    .cell_row      (cell_row),
    .map_addr      (map_addr),
    .map_data      (map_data),
    .drawer_active (drawer_active),
    .draw          (draw),
    .tile_address  (tile_address),
    .x_pos         (x_pos),
    .y_pos         (y_pos),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .tiles_drawn   (tiles_drawn)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  x;
    logic [7:0]  y;
  } exp_t;

  logic [7:0] map_mem [0:511];
  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  int         draws = 0;
  int         done_cnt = 0;
  int         cyc = 0;
  int         last_draw_cyc = -1;
  int         run_cnt;
  logic       ack_en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Synchronous map RAM
  always @(posedge clk) map_data <= map_mem[map_addr];

  // Drawer: goes active the edge after draw, stays active BUSY_LEN+1 cycles
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drawer_active <= 1'b0;
      run_cnt       <= 0;
    end else if (drawer_active) begin
      if (run_cnt == 0) drawer_active <= 1'b0;
      else run_cnt <= run_cnt - 1;
    end else if (draw && ack_en) begin
      drawer_active <= 1'b1;
      run_cnt       <= BUSY_LEN;
    end
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) if (done) done_cnt++;

  // Draw monitor: pops the scoreboard and checks the drawer parameters
  always @(negedge clk) begin
    exp_t e;
    if (resetn && draw) begin
      draws++;
      check("draw_while_active", drawer_active, 0);
      if (!ack_en && last_draw_cyc >= 0) check("timeout_gap", cyc - last_draw_cyc, 12);
      last_draw_cyc = cyc;
      check("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("tile_address", tile_address, e.addr);
        check("x_pos", x_pos, e.x);
        check("y_pos", y_pos, e.y);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tile(input int idx, input int col, input int row);
    exp_t e;
    int   k;
    k      = (idx >= 21) ? 0 : idx;
    e.addr = 12'(k * 192);
    e.x    = 8'(col * 8);
    e.y    = 8'(row * 8);
    sb.push_back(e);
  endtask

  task automatic push_full();
    for (int i = 0; i < 300; i++) push_tile(int'(map_mem[i]), i % 20, i / 20);
  endtask

  // Inputs held for exactly one rising edge; returns half a cycle after it
  task automatic pulse(input logic s, input logic sc, input int col, input int row);
    @(negedge clk);
    start      = s;
    start_cell = sc;
    cell_col   = 5'(col);
    cell_row   = 4'(row);
    @(negedge clk);
    start      = 1'b0;
    start_cell = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int   n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
    check("done_seen", seen, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_draw"}, draw, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_tiles"}, tiles_drawn, 0);
    check({tag, "_map_addr"}, map_addr, 0);
    check({tag, "_tile_addr"}, tile_address, 0);
    check({tag, "_x"}, x_pos, 0);
    check({tag, "_y"}, y_pos, 0);
  endtask

  initial begin
    int d0, dc, n;
    resetn     = 1'b0;
    start      = 1'b0;
    start_cell = 1'b0;
    cell_col   = '0;
    cell_row   = '0;
    ack_en     = 1'b1;
    for (int i = 0; i < 512; i++) map_mem[i] = 8'(i % 21);

    // Reset state
    tick(3);
    check_all_zero("reset");
    resetn = 1'b1;
    tick(2);

    // Full pass with first-tile latency
    d0 = draws; dc = done_cnt;
    push_full();
    pulse(1'b1, 1'b0, 0, 0);
    check("busy_after_start", busy, 1);
    check("map_addr_first", map_addr, 0);
    tick(2);
    check("draw_before_n3", draw, 0);
    tick(1);
    check("draw_at_n3", draw, 1);
    wait_done(6000);
    check("full_busy_at_done", busy, 0);
    check("full_tiles", tiles_drawn, 300);
    check("full_err", err, 0);
    check("full_draws", draws - d0, 300);
    check("full_sb_empty", sb.size(), 0);
    check("last_addr", tile_address, 960);
    check("last_x", x_pos, 152);
    check("last_y", y_pos, 112);
    tick(3);
    check("full_done_once", done_cnt - dc, 1);

    // Single cell (3,2) holding index 20
    map_mem[43] = 8'd20;
    d0 = draws;
    push_tile(20, 3, 2);
    pulse(1'b0, 1'b1, 3, 2);
    wait_done(500);
    check("cell_tiles", tiles_drawn, 1);
    check("cell_draws", draws - d0, 1);
    check("cell_err", err, 0);
    check("cell_addr", tile_address, 3840);
    check("cell_x", x_pos, 24);
    check("cell_y", y_pos, 16);
    check("cell_sb_empty", sb.size(), 0);

    // Out-of-range map index falls back to tile 0 and sets sticky err
    map_mem[0] = 8'd25;
    push_tile(25, 0, 0);
    pulse(1'b0, 1'b1, 0, 0);
    wait_done(500);
    check("badidx_err", err, 1);
    check("badidx_tiles", tiles_drawn, 1);
    check("badidx_addr", tile_address, 0);
    tick(20);
    check("badidx_err_sticky", err, 1);

    // Off-map cell: done with err, no draw, stays idle
    d0 = draws;
    pulse(1'b0, 1'b1, 20, 0);
    check("offmap_done", done, 1);
    check("offmap_err", err, 1);
    check("offmap_busy", busy, 0);
    tick(5);
    check("offmap_draws", draws - d0, 0);
    check("offmap_busy_later", busy, 0);

    // start+start_cell together runs a full pass; pulses while busy are ignored
    map_mem[0] = 8'd0;
    d0 = draws;
    push_full();
    pulse(1'b1, 1'b1, 5, 5);
    check("both_err_cleared", err, 0);
    check("both_busy", busy, 1);
    tick(100);
    pulse(1'b1, 1'b1, 1, 1);
    tick(50);
    pulse(1'b1, 1'b0, 0, 0);
    wait_done(6000);
    check("both_tiles", tiles_drawn, 300);
    check("both_draws", draws - d0, 300);
    check("both_sb_empty", sb.size(), 0);
    tick(20);
    check("ignored_not_queued", busy, 0);
    check("both_draws_after", draws - d0, 300);

    // Drawer never acknowledges: every tile times out
    ack_en = 1'b0;
    last_draw_cyc = -1;
    d0 = draws;
    push_full();
    pulse(1'b1, 1'b0, 0, 0);
    wait_done(8000);
    check("to_tiles", tiles_drawn, 0);
    check("to_err", err, 1);
    check("to_draws", draws - d0, 300);
    check("to_sb_empty", sb.size(), 0);
    ack_en = 1'b1;
    tick(2);

    // Reset during the 50th tile's drawer run
    d0 = draws; dc = done_cnt;
    push_full();
    pulse(1'b1, 1'b0, 0, 0);
    n = 0;
    while (!((draws - d0) == 50 && drawer_active) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reached_tile50", (draws - d0) == 50 && drawer_active, 1);
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero("midreset");
    sb.delete();
    tick(3);
    check("midreset_no_done", done_cnt - dc, 0);
    resetn = 1'b1;
    tick(2);
    d0 = draws;
    push_full();
    pulse(1'b1, 1'b0, 0, 0);
    wait_done(6000);
    check("restart_tiles", tiles_drawn, 300);
    check("restart_draws", draws - d0, 300);
    check("restart_sb_empty", sb.size(), 0);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
